// File: rtl/jesd204_versal_gt_adapter_rx_pkg.sv
// jesd204_versal_gt_adapter_rx_pkg: shared FSM encodings, default thresholds and header helper
package jesd204_versal_gt_adapter_rx_pkg;
   typedef enum logic [1:0] {HUNT = 2'd0, SLIP = 2'd1, LOCKED = 2'd2} sync_state_t;
   localparam int LOCK_CNT_DEF    = 64;
   localparam int INVALID_MAX_DEF = 16;
   localparam int WINDOW_DEF      = 64;
   localparam int SLIP_WAIT_DEF   = 32;
   // 64b/66b sync headers are valid only when the two bits differ
   function automatic logic hdr_ok(input logic [1:0] h);
      return h[1] ^ h[0];
   endfunction
endpackage

// File: rtl/jesd204_rx_header_sync.sv
// jesd204_rx_header_sync: sync-header block-lock FSM with gearbox slip and lock-loss window
module jesd204_rx_header_sync
   import jesd204_versal_gt_adapter_rx_pkg::*;
#(
   parameter int LOCK_CNT    = LOCK_CNT_DEF,
   parameter int INVALID_MAX = INVALID_MAX_DEF,
   parameter int WINDOW      = WINDOW_DEF,
   parameter int SLIP_WAIT   = SLIP_WAIT_DEF
)(
   input  logic        usr_clk,
   input  logic        reset,
   input  logic [1:0]  hdr,
   input  logic        hdr_valid,
   output logic        slip,
   output logic        block_sync,
   output logic [15:0] err_cnt
);
   sync_state_t state, state_n;
   logic [15:0] good_cnt, good_n, hdr_cnt, hdr_n, inv_cnt, inv_n, wait_cnt, wait_n;
   logic ok, slip_n;
   assign ok = hdr_ok(hdr);
   always_comb begin
      state_n = state;
      good_n  = good_cnt;
      hdr_n   = hdr_cnt;
      inv_n   = inv_cnt;
      wait_n  = wait_cnt;
      slip_n  = 1'b0;
      case (state)
         HUNT: if (hdr_valid) begin
            if (!ok) begin
               good_n  = '0;
               wait_n  = '0;
               slip_n  = 1'b1;
               state_n = SLIP;
            end else if (good_cnt + 16'd1 == 16'(LOCK_CNT)) begin
               good_n  = '0;
               hdr_n   = '0;
               inv_n   = '0;
               state_n = LOCKED;
            end else good_n = good_cnt + 16'd1;
         end
         // the slip wait runs on every cycle, header qualifier or not
         SLIP: begin
            wait_n  = (wait_cnt == 16'(SLIP_WAIT - 1)) ? '0 : wait_cnt + 16'd1;
            state_n = (wait_cnt == 16'(SLIP_WAIT - 1)) ? HUNT : SLIP;
         end
         LOCKED: if (hdr_valid) begin
            hdr_n = hdr_cnt + 16'd1;
            inv_n = inv_cnt + {15'd0, !ok};
            if (inv_n == 16'(INVALID_MAX)) begin
               state_n = HUNT;
               good_n  = '0;
               hdr_n   = '0;
               inv_n   = '0;
            end else if (hdr_n == 16'(WINDOW)) begin
               hdr_n = '0;
               inv_n = '0;
            end
         end
         default: state_n = HUNT;
      endcase
   end
   always_ff @(posedge usr_clk or posedge reset) begin
      if (reset) begin
         state      <= HUNT;
         good_cnt   <= '0;
         hdr_cnt    <= '0;
         inv_cnt    <= '0;
         wait_cnt   <= '0;
         slip       <= 1'b0;
         block_sync <= 1'b0;
      end else begin
         state      <= state_n;
         good_cnt   <= good_n;
         hdr_cnt    <= hdr_n;
         inv_cnt    <= inv_n;
         wait_cnt   <= wait_n;
         slip       <= slip_n;
         block_sync <= (state_n == LOCKED);
      end
   end
`ifdef JESD204_RX_HDR_ERR_CNT_EN
   always_ff @(posedge usr_clk or posedge reset) begin
      if (reset) err_cnt <= '0;
      else if (state == LOCKED && hdr_valid && !ok && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
   end
`else
   assign err_cnt = '0;
`endif
endmodule

// File: rtl/jesd204_versal_gt_adapter_rx.sv
// jesd204_versal_gt_adapter_rx: Versal GT RX to JESD204C link-layer adapter (bit flip + block lock)
// Define JESD204_RX_HDR_ERR_CNT_EN to build the saturating invalid-header counter.
module jesd204_versal_gt_adapter_rx
   import jesd204_versal_gt_adapter_rx_pkg::*;
#(
   parameter int LOCK_CNT    = LOCK_CNT_DEF,
   parameter int INVALID_MAX = INVALID_MAX_DEF,
   parameter int WINDOW      = WINDOW_DEF,
   parameter int SLIP_WAIT   = SLIP_WAIT_DEF
)(
   input  logic         usr_clk,
   input  logic         reset,
   input  logic [127:0] rxdata,
   input  logic [5:0]   rxheader,
   input  logic [1:0]   rxdatavalid,
   input  logic [1:0]   rxheadervalid,
   output logic         rxgearboxslip,
   output logic [63:0]  rx_data,
   output logic [1:0]   rx_header,
   output logic         rx_valid,
   output logic         rx_block_sync,
   output logic [15:0]  rx_hdr_err_cnt
);
   logic [63:0] data_rev;
   logic unused;
   assign unused   = ^{rxdata[127:64], rxheader[5:2], rxdatavalid[1], rxheadervalid[1]};
   assign data_rev = {<<{rxdata[63:0]}};
   // the GT delivers bits LSB-first, the link layer expects them MSB-first
   always_ff @(posedge usr_clk or posedge reset) begin
      if (reset) begin
         rx_data   <= '0;
         rx_header <= '0;
         rx_valid  <= 1'b0;
      end else begin
         rx_valid <= rxdatavalid[0];
         if (rxdatavalid[0]) begin
            rx_data   <= data_rev;
            rx_header <= {rxheader[0], rxheader[1]};
         end
      end
   end
   jesd204_rx_header_sync #(
      .LOCK_CNT(LOCK_CNT),
      .INVALID_MAX(INVALID_MAX),
      .WINDOW(WINDOW),
      .SLIP_WAIT(SLIP_WAIT)
   ) u_header_sync (
      .usr_clk(usr_clk),
      .reset(reset),
      .hdr(rxheader[1:0]),
      .hdr_valid(rxheadervalid[0]),
      .slip(rxgearboxslip),
      .block_sync(rx_block_sync),
      .err_cnt(rx_hdr_err_cnt)
   );
endmodule

// File: tb/tb_jesd204_versal_gt_adapter_rx.sv
// tb_jesd204_versal_gt_adapter_rx: scoreboard bench for data flip, block lock, slip and reset
module tb_jesd204_versal_gt_adapter_rx;
   logic         usr_clk = 1'b0;
   logic         reset = 1'b0;
   logic [127:0] rxdata = '0;
   logic [5:0]   rxheader = '0;
   logic [1:0]   rxdatavalid = '0;
   logic [1:0]   rxheadervalid = '0;
   logic         rxgearboxslip;
   logic [63:0]  rx_data;
   logic [1:0]   rx_header;
   logic         rx_valid;
   logic         rx_block_sync;
   logic [15:0]  rx_hdr_err_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int slip_pulses = 0;
   logic slip_prev = 1'b0;
   logic [65:0] sb[$];
   logic [65:0] last_exp = '0;

   jesd204_versal_gt_adapter_rx dut (
      .usr_clk(usr_clk),
      .reset(reset),
      .rxdata(rxdata),
      .rxheader(rxheader),
      .rxdatavalid(rxdatavalid),
      .rxheadervalid(rxheadervalid),
      .rxgearboxslip(rxgearboxslip),
      .rx_data(rx_data),
      .rx_header(rx_header),
      .rx_valid(rx_valid),
      .rx_block_sync(rx_block_sync),
      .rx_hdr_err_cnt(rx_hdr_err_cnt)
   );

   always #5 usr_clk = ~usr_clk;

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_d(input logic [63:0] d, input logic [1:0] h, input logic hv, input logic dv);
      logic [63:0] r;
      @(negedge usr_clk);
      rxdata        = {64'($urandom) << 32 | 64'($urandom), d};
      rxheader      = {4'($urandom), h};
      rxheadervalid = {1'($urandom), hv};
      rxdatavalid   = {1'($urandom), dv};
      r = {<<{d}};
      if (dv) sb.push_back({r, h[0], h[1]});
   endtask

   task automatic drive(input logic [1:0] h, input logic hv);
      drive_d({32'($urandom), 32'($urandom)}, h, hv, 1'($urandom_range(0, 3) != 0));
   endtask

   function automatic logic [1:0] good_hdr();
      return $urandom_range(0, 1) ? 2'b01 : 2'b10;
   endfunction

   task automatic settle();
      @(posedge usr_clk);
      #2;
      rxheadervalid = '0;
      rxdatavalid   = '0;
   endtask

   task automatic run_hdrs(input int n, input int lo, input int hi);
      for (int k = 0; k < n; k++) drive((k >= lo && k < hi) ? 2'b11 : good_hdr(), 1'b1);
   endtask

   task automatic reset_dut();
      @(negedge usr_clk);
      reset = 1'b1;
      sb.delete();
      last_exp = '0;
      rxheadervalid = '0;
      rxdatavalid = '0;
      repeat (2) @(negedge usr_clk);
      reset = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_data"}, 80'(rx_data), 80'(0));
      check({tag, "_hdr"}, 80'(rx_header), 80'(0));
      check({tag, "_valid"}, 80'(rx_valid), 80'(0));
      check({tag, "_sync"}, 80'(rx_block_sync), 80'(0));
      check({tag, "_slip"}, 80'(rxgearboxslip), 80'(0));
      check({tag, "_errcnt"}, 80'(rx_hdr_err_cnt), 80'(0));
   endtask

   // output monitor: pop scoreboard on rx_valid, otherwise outputs must hold
   always @(posedge usr_clk) begin
      logic [65:0] e;
      #1;
      if (!reset) begin
         if (rxgearboxslip) begin
            check("slip_width", 80'(slip_prev), 80'(0));
            slip_pulses++;
         end
         slip_prev = rxgearboxslip;
         if (rx_valid) begin
            if (sb.size() == 0) check("sb_underflow", 80'(sb.size()), 80'(1));
            else begin
               e = sb.pop_front();
               check("rx_out", 80'({rx_data, rx_header}), 80'(e));
               last_exp = e;
            end
         end else check("rx_hold", 80'({rx_data, rx_header}), 80'(last_exp));
      end
   end

   initial begin
      #3 reset = 1'b1;
      #1 check_zero("reset");
      @(negedge usr_clk);
      reset = 1'b0;

      drive_d(64'h1, 2'b01, 1'b0, 1'b1);
      settle();
      check("flip_data", 80'(rx_data), 80'(64'h8000_0000_0000_0000));
      check("flip_hdr", 80'(rx_header), 80'(2'b10));

      run_hdrs(63, 0, 0);
      settle();
      check("hunt_63", 80'(rx_block_sync), 80'(0));
      run_hdrs(1, 0, 0);
      settle();
      check("lock_64", 80'(rx_block_sync), 80'(1));
      check("lock_no_slip", 80'(slip_pulses), 80'(0));

      run_hdrs(64, 49, 64);
      settle();
      check("win1_hold", 80'(rx_block_sync), 80'(1));
      run_hdrs(64, 0, 15);
      settle();
      check("win2_cleared", 80'(rx_block_sync), 80'(1));
      run_hdrs(63, 48, 63);
      settle();
      check("win3_15inv", 80'(rx_block_sync), 80'(1));
      run_hdrs(1, 0, 1);
      settle();
      check("coincide_drop", 80'(rx_block_sync), 80'(0));
`ifdef JESD204_RX_HDR_ERR_CNT_EN
      check("err_cnt_windows", 80'(rx_hdr_err_cnt), 80'(46));
`else
      check("err_cnt_windows", 80'(rx_hdr_err_cnt), 80'(0));
`endif

      run_hdrs(10, 9, 10);
      settle();
      check("slip_pulse", 80'(rxgearboxslip), 80'(1));
      run_hdrs(29, 0, 29);
      repeat (10) drive(2'b11, 1'b0);
      settle();
      check("slip_once", 80'(slip_pulses), 80'(1));
      check("slip_no_sync", 80'(rx_block_sync), 80'(0));
      run_hdrs(63, 0, 0);
      settle();
      check("relock_63", 80'(rx_block_sync), 80'(0));
      run_hdrs(1, 0, 0);
      settle();
      check("relock_64", 80'(rx_block_sync), 80'(1));

      reset_dut();
      run_hdrs(64, 63, 64);
      settle();
      check("last_inv_slip", 80'(rxgearboxslip), 80'(1));
      check("last_inv_nolock", 80'(rx_block_sync), 80'(0));
      check("last_inv_pulses", 80'(slip_pulses), 80'(2));

      repeat (3) drive(2'b11, 1'b0);
      @(posedge usr_clk);
      #3 reset = 1'b1;
      #1 check_zero("rst_slip");
      sb.delete();
      last_exp = '0;
      rxheadervalid = '0;
      rxdatavalid = '0;
      @(negedge usr_clk);
      reset = 1'b0;
      run_hdrs(63, 0, 0);
      settle();
      check("post_rst_63", 80'(rx_block_sync), 80'(0));
      run_hdrs(1, 0, 0);
      settle();
      check("post_rst_lock", 80'(rx_block_sync), 80'(1));

      reset_dut();
      run_hdrs(64, 0, 0);
      run_hdrs(5, 0, 5);
      settle();
      check("err_lock_held", 80'(rx_block_sync), 80'(1));
`ifdef JESD204_RX_HDR_ERR_CNT_EN
      check("err_cnt_5", 80'(rx_hdr_err_cnt), 80'(5));
`else
      check("err_cnt_5", 80'(rx_hdr_err_cnt), 80'(0));
`endif
      settle();
      check("sb_drain", 80'(sb.size()), 80'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
